// File: rtl/aesha_msg_feeder_pkg.sv
// Shared constants and state encoding for the AES/SHA3 message feeder.
package aesha_msg_feeder_pkg;

  localparam logic [1:0] MODE_AES_ENC = 2'd0;
  localparam logic [1:0] MODE_AES_DEC = 2'd1;
  localparam logic [1:0] MODE_SHA3    = 2'd2;

  localparam int MAX_BYTES = 32;

  localparam logic [5:0] AES_OUT_BYTES = 6'd16;
  localparam logic [5:0] SHA_OUT_BYTES = 6'd32;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_SEND  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Length of the core's output burst for a given mode; both 2 and 3 mean SHA3.
  function automatic logic [5:0] exp_out_bytes(input logic [1:0] mode);
    logic [5:0] n;
    case (mode)
      MODE_AES_ENC, MODE_AES_DEC: n = AES_OUT_BYTES;
      MODE_SHA3:                  n = SHA_OUT_BYTES;
      default:                    n = SHA_OUT_BYTES;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/aesha_msg_buf.sv
// Message byte store: random-access write port, sequential read pointer for replay.
module aesha_msg_buf #(
  parameter int DEPTH = aesha_msg_feeder_pkg::MAX_BYTES,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          rd_clr,
  input  logic          rd_en,
  output logic [7:0]    rd_data
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rd_ptr <= '0;
    else if (rd_clr) rd_ptr <= '0;
    else if (rd_en)  rd_ptr <= rd_ptr + AW'(1);
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/aesha_msg_feeder.sv
// Buffers a 1..32 byte host message, replays it to the AES/SHA3 core as one
// gap-free start burst, then checks the length of the core's output burst.
module aesha_msg_feeder #(
  parameter int MAX_BYTES = aesha_msg_feeder_pkg::MAX_BYTES,
  parameter int TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  input  logic [1:0] s_mode,
  output logic [7:0] core_data,
  output logic       core_start,
  output logic [1:0] core_mode,
  input  logic       core_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);
  import aesha_msg_feeder_pkg::*;

  localparam int              AW       = $clog2(MAX_BYTES);
  localparam int              TW       = $clog2(TIMEOUT) + 1;
  localparam logic [5:0]      LAST_IDX = 6'(MAX_BYTES - 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state, state_nxt;
  logic [5:0]    wr_ptr, wr_ptr_nxt;
  logic [5:0]    len_r, len_nxt;
  logic [5:0]    snt_cnt, snt_nxt;
  logic [5:0]    out_cnt, out_nxt;
  logic [1:0]    mode_r, mode_nxt;
  logic [1:0]    core_mode_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [7:0]    core_data_nxt;
  logic          core_start_nxt, done_nxt, err_nxt;
  logic          hs, last_hs;
  logic          buf_rd_clr, buf_rd_en;
  logic [7:0]    rd_data;

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

  assign s_ready = (state == ST_FILL);
  assign busy    = !((state == ST_FILL) && (wr_ptr == 6'd0));
  assign hs      = s_valid & s_ready;
  assign last_hs = hs & (s_last | (wr_ptr == LAST_IDX));

  aesha_msg_buf #(.DEPTH(MAX_BYTES), .AW(AW)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (hs),
    .waddr   (wr_ptr[AW-1:0]),
    .wdata   (s_data),
    .rd_clr  (buf_rd_clr),
    .rd_en   (buf_rd_en),
    .rd_data (rd_data)
  );

  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    len_nxt        = len_r;
    snt_nxt        = snt_cnt;
    out_nxt        = out_cnt;
    mode_nxt       = mode_r;
    tmo_nxt        = tmo_cnt;
    core_data_nxt  = core_data;
    core_mode_nxt  = core_mode;
    core_start_nxt = 1'b0;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;
    buf_rd_clr     = 1'b0;
    buf_rd_en      = 1'b0;

    case (state)
      ST_FILL: begin
        if (hs) begin
          wr_ptr_nxt = wr_ptr + 6'd1;
          if (wr_ptr == 6'd0) mode_nxt = s_mode;
        end
        // The first burst byte leaves on this edge; a one-byte message is
        // still on s_data, not yet in the buffer.
        if (last_hs) begin
          state_nxt      = ST_SEND;
          len_nxt        = wr_ptr + 6'd1;
          wr_ptr_nxt     = 6'd0;
          snt_nxt        = 6'd1;
          core_start_nxt = 1'b1;
          core_data_nxt  = (wr_ptr == 6'd0) ? s_data : rd_data;
          core_mode_nxt  = (wr_ptr == 6'd0) ? s_mode : mode_r;
          buf_rd_en      = 1'b1;
        end
      end
      ST_SEND: begin
        if (snt_cnt < len_r) begin
          core_start_nxt = 1'b1;
          core_data_nxt  = rd_data;
          buf_rd_en      = 1'b1;
          snt_nxt        = snt_cnt + 6'd1;
        end else begin
          state_nxt  = ST_WAIT;
          buf_rd_clr = 1'b1;
          // Counts cycles elapsed since the last start cycle.
          tmo_nxt    = TW'(1);
        end
      end
      ST_WAIT: begin
        if (core_valid) begin
          state_nxt = ST_DRAIN;
          out_nxt   = 6'd1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ST_FILL;
          err_nxt   = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end
      ST_DRAIN: begin
        if (core_valid) begin
          out_nxt = sat_inc6(out_cnt);
        end else begin
          state_nxt = ST_FILL;
          if (out_cnt == exp_out_bytes(mode_r)) done_nxt = 1'b1;
          else                                  err_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FILL;
      wr_ptr     <= 6'd0;
      len_r      <= 6'd0;
      snt_cnt    <= 6'd0;
      out_cnt    <= 6'd0;
      mode_r     <= 2'd0;
      tmo_cnt    <= '0;
      core_data  <= 8'd0;
      core_start <= 1'b0;
      core_mode  <= 2'd0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      len_r      <= len_nxt;
      snt_cnt    <= snt_nxt;
      out_cnt    <= out_nxt;
      mode_r     <= mode_nxt;
      tmo_cnt    <= tmo_nxt;
      core_data  <= core_data_nxt;
      core_start <= core_start_nxt;
      core_mode  <= core_mode_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_aesha_msg_feeder.sv
// Directed bench for aesha_msg_feeder: scoreboard of expected core bytes,
// modelled core output bursts, status pulse and timing checks.
module tb_aesha_msg_feeder;
  import aesha_msg_feeder_pkg::*;

  localparam int TIMEOUT = 1024;

  logic       clk, rst_n;
  logic       s_valid, s_ready, s_last;
  logic [7:0] s_data;
  logic [1:0] s_mode;
  logic [7:0] core_data;
  logic       core_start;
  logic [1:0] core_mode;
  logic       core_valid;
  logic       busy, done, err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  logic [1:0] exp_mode = 2'd0;
  int run_len = 0, last_burst = 0, nbursts = 0, last_start_cyc = 0;

  aesha_msg_feeder #(.MAX_BYTES(32), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_mode     (s_mode),
    .core_data  (core_data),
    .core_start (core_start),
    .core_mode  (core_mode),
    .core_valid (core_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core-side monitor: every start cycle must carry the next scoreboard byte.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && core_start) begin
        run_len++;
        last_start_cyc = cyc;
        if (exp_q.size() == 0) check("core_extra_start", 1, 0);
        else begin
          b = exp_q.pop_front();
          check("core_data", core_data, b);
        end
        check("core_mode", core_mode, exp_mode);
      end else if (run_len != 0) begin
        last_burst = run_len;
        nbursts++;
        run_len = 0;
      end
    end
  end

  task automatic put_byte(input logic [7:0] d, input logic last, input logic [1:0] mode);
    int t;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = last; s_mode = mode;
    t = 0;
    while (!s_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("put_byte_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic drive_valid(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      core_valid = 1'b1;
    end
    @(negedge clk);
    core_valid = 1'b0;
  endtask

  task automatic run_msg(input string tag, input logic [1:0] mode, input int n,
                         input logic [7:0] base, input bit use_last, input bit hold,
                         input int nvalid, input bit exp_done, input bit chk_tmo);
    int nb0, t;
    logic [1:0] m;
    nb0 = nbursts;
    exp_mode = mode;
    for (int i = 0; i < n; i++) begin
      m = (hold && i > 0) ? 2'(mode + 2'(i)) : mode;
      exp_q.push_back(8'(base + 8'(i)));
      put_byte(8'(base + 8'(i)), use_last && (i == n - 1), m);
      if (i == 0 && n > 1) check({tag, "_busy_fill"}, busy, 1);
    end
    if (!use_last) begin
      @(negedge clk);
      check({tag, "_full_ready"}, s_ready, 0);
    end
    if (hold) begin
      s_valid = 1'b1; s_data = 8'hEE; s_mode = ~mode;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check({tag, "_bp_ready"}, s_ready, 0);
      end
      s_valid = 1'b0;
    end
    t = 0;
    while (nbursts == nb0 && t < 200) begin @(negedge clk); t++; end
    check({tag, "_nbursts"}, nbursts, nb0 + 1);
    check({tag, "_burst_len"}, last_burst, n);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    if (nvalid > 0) drive_valid(nvalid);
    t = 0;
    while (!(done || err) && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) check({tag, "_status_timeout"}, 0, 1);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_err"}, err, !exp_done);
    check({tag, "_ready_at_status"}, s_ready, 1);
    check({tag, "_mode_held"}, core_mode, mode);
    if (chk_tmo) check({tag, "_tmo_cycles"}, cyc - last_start_cyc, TIMEOUT);
    @(negedge clk);
    check({tag, "_pulse_end"}, {done, err}, 2'b00);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int k, t;
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'd0; s_mode = 2'd0;
    core_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_core_start", core_start, 0);
    check("rst_core_data", core_data, 0);
    check("rst_core_mode", core_mode, 0);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 2'b00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_msg("sha_abc", MODE_SHA3, 3, 8'h61, 1, 0, 32, 1, 0);
    run_msg("aes_full", MODE_AES_ENC, 32, 8'h00, 0, 0, 16, 1, 0);
    run_msg("len_mismatch", MODE_AES_DEC, 1, 8'hA5, 1, 0, 32, 0, 0);
    run_msg("timeout", MODE_SHA3, 5, 8'h10, 1, 0, 0, 0, 1);
    run_msg("bp_mode", MODE_AES_ENC, 4, 8'hC0, 1, 1, 16, 1, 0);

    // Asynchronous reset on the third start cycle of a 6-byte burst.
    exp_mode = MODE_AES_ENC;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(8'(8'h80 + 8'(i)));
      put_byte(8'(8'h80 + 8'(i)), i == 5, MODE_AES_ENC);
    end
    k = 0; t = 0;
    while (k < 3 && t < 100) begin
      @(negedge clk);
      if (core_start) k++;
      t++;
    end
    check("rstmid_reach_third", k, 3);
    rst_n = 1'b0;
    #1;
    check("rstmid_core_start", core_start, 0);
    check("rstmid_core_data", core_data, 0);
    check("rstmid_core_mode", core_mode, 0);
    check("rstmid_s_ready", s_ready, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_done_err", {done, err}, 2'b00);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_msg("after_rst", MODE_SHA3, 4, 8'h40, 1, 0, 32, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aesha_msg_feeder.md
Name: aesha_msg_feeder

Overview:
- Upstream stage of the AES/SHA3 byte-serial core.
- Accepts a host message (1..32 bytes) over a valid/ready byte stream and buffers it whole. Replays it to the core as one gap-free burst, because any gap in the core's start strobe is taken as end-of-message and triggers padding.
- Holds the core mode stable for the whole operation, then tracks the core's output burst. Reports done, busy and error status.

Parameters:
- MAX_BYTES, 32, message buffer depth in bytes; fixed by the core's 256-bit buffer.
- TIMEOUT, 1024, max cycles from end of SEND to the first core_valid before aborting.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  host byte valid
- s_ready  out  1  feeder accepts a byte this cycle
- s_data  in  8  host message byte
- s_last  in  1  marks the final byte of the message
- s_mode  in  2  0 AES-enc, 1 AES-dec, 2/3 SHA3-256; sampled with the first byte only
- core_data  out  8  byte driven to the core
- core_start  out  1  core byte strobe; contiguous for the whole message
- core_mode  out  2  mode to the core; held from SEND through DRAIN
- core_valid  in  1  core output-byte valid
- busy  out  1  high in any state other than FILL-empty
- done  out  1  one-cycle pulse when the core's output burst ends correctly
- err  out  1  one-cycle pulse on timeout or output-length mismatch

Behaviour:
- Reset values: s_ready=1, core_start=0, core_data=0, core_mode=0, busy=0, done=0, err=0, state FILL, wr_ptr=0.
  - Reset is asynchronous and valid in any state; an in-flight message is discarded.
- All core-side outputs are registered.
- FILL state:
  - s_ready=1. A handshake occurs when s_valid&s_ready; the byte is written to buf[wr_ptr] and wr_ptr increments.
  - The first accepted byte latches s_mode into mode_r.
  - Exit to SEND when s_last is accepted, or when the 32nd byte is accepted (an implicit last; the 33rd byte is never accepted). len_r = wr_ptr+1.
- SEND state:
  - s_ready=0.
  - Starting the cycle after the last handshake, core_start=1 for exactly len_r consecutive cycles, with core_data=buf[0..len_r-1] in order.
  - The feeder does no bit reordering; the core performs SHA3 bit reversal itself.
  - Next state is WAIT.
- WAIT state:
  - core_start=0 and a timeout counter counts up.
  - On core_valid=1, go to DRAIN with out_cnt=1.
  - If the counter reaches TIMEOUT, pulse err and go to FILL.
- DRAIN state:
  - out_cnt increments each cycle core_valid=1.
  - When core_valid falls, compare out_cnt with the expected count: 16 if mode_r[1]=0, 32 if mode_r[1]=1.
    - Equal: pulse done.
    - Not equal: pulse err.
  - In either case go to FILL; s_ready returns to 1 in the same cycle done/err is asserted.
- core_mode equals mode_r in SEND/WAIT/DRAIN. In FILL it keeps the last value; it is never changed mid-operation.
- core_valid outside WAIT/DRAIN is ignored.
- s_valid with s_ready=0 is ignored; the host must hold the byte.
- Widths:
  - wr_ptr and len counters are 6 bits (values 0..32).
  - out_cnt is 6 bits and saturates at 63.
  - The timeout counter is clog2(TIMEOUT)+1 bits.
- done and err are never asserted in the same cycle.

Decomposition:
- Shared package holds:
  - mode encodings MODE_AES_ENC=0, MODE_AES_DEC=1, MODE_SHA3=2
  - MAX_BYTES
  - AES_OUT_BYTES=16, SHA_OUT_BYTES=32
  - state encoding FILL/SEND/WAIT/DRAIN
- One natural sub-module, aesha_msg_buf: a 32x8 register file with a write port and a sequential read pointer. The FSM stays in the top of the block.

Test Plan:
- SHA3 "abc":
  - Stimulus: mode=2, bytes 0x61,0x62,0x63 with s_last on 0x63; model core_valid high for 32 cycles.
  - Required: core_start high exactly 3 consecutive cycles carrying 61,62,63; core_mode=2 throughout; single done pulse; err=0.
- AES full block:
  - Stimulus: mode=0, 32 bytes 0x00..0x1F, no s_last; core_valid high for 16 cycles.
  - Required: s_ready drops after byte 0x1F; 32-cycle contiguous burst; done pulse.
- Length mismatch:
  - Stimulus: mode=1, one byte with s_last; core_valid high for 32 cycles.
  - Required: err pulse, no done; FILL reentered with s_ready=1.
- Timeout:
  - Stimulus: mode=2, 5 bytes; core_valid never asserted.
  - Required: err pulse exactly TIMEOUT cycles after the last core_start cycle; busy=0 the cycle after.
- Back-pressure and mode latch:
  - Stimulus: s_valid held during SEND/WAIT; s_mode toggles after the first byte.
  - Required: no extra byte accepted; core_mode stays at the first-byte value.
- Reset mid-SEND:
  - Stimulus: rst_n low on the 3rd core_start cycle.
  - Required: core_start=0 immediately; all outputs at reset values; a following 4-byte message bursts correctly.
